// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: req/resp data-memory controller between the core and data_ram with byte/half/word
// access, sign/zero extension and misalignment trapping. Define DATA_MEM_STAT_EN for access counters.
module data_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              addr_err,
  output logic              stall,
  output logic              ram_en,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ERR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lat_we, lat_uns;
  logic [1:0]       lat_size, lat_lane;
  logic [3:0]       lat_wea;
  logic             accept, misaligned, load_done, store_done;
  logic [3:0]       wea_nxt;
  logic [31:0]      din_nxt, load_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign accept     = (state == S_IDLE) && req_valid;
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
  assign load_done  = (state == S_WAIT) && (cnt == '0);
  assign store_done = (state == S_ACCESS) && lat_we;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    wea_nxt = 4'hF;
    din_nxt = req_wdata;
    case (req_size)
      2'd0: begin
        wea_nxt = 4'b0001 << req_addr[1:0];
        din_nxt = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        wea_nxt = 4'b0011 << {req_addr[1], 1'b0};
        din_nxt = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane pick and extension of the word returned by the RAM.
  always_comb begin
    case (lat_lane)
      2'd0:    ld_byte = ram_dout[7:0];
      2'd1:    ld_byte = ram_dout[15:8];
      2'd2:    ld_byte = ram_dout[23:16];
      default: ld_byte = ram_dout[31:24];
    endcase
    ld_half = lat_lane[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (lat_size)
      2'd0:    load_data = {{24{~lat_uns & ld_byte[7]}}, ld_byte};
      2'd1:    load_data = {{16{~lat_uns & ld_half[15]}}, ld_half};
      default: load_data = ram_dout;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = misaligned ? S_ERR : S_ACCESS;
      S_ACCESS: state_nxt = lat_we ? S_IDLE : S_WAIT;
      S_WAIT:   if (cnt == '0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // The final WAIT cycle only samples ram_dout, so the enable drops there.
  assign ram_en    = (state == S_ACCESS) || ((state == S_WAIT) && (cnt != '0));
  assign ram_wea   = store_done ? lat_wea : 4'b0000;
  assign req_ready = (state == S_IDLE);
  assign stall     = req_valid & ~resp_valid;

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_uns    <= 1'b0;
      lat_size   <= 2'd0;
      lat_lane   <= 2'd0;
      lat_wea    <= 4'b0000;
      ram_addr   <= '0;
      ram_din    <= '0;
      resp_valid <= 1'b0;
      addr_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      resp_valid <= store_done || load_done || (state == S_ERR);
      addr_err   <= (state == S_ERR);
      if (accept) begin
        lat_we   <= req_we;
        lat_uns  <= req_unsigned;
        lat_size <= req_size;
        lat_lane <= req_addr[1:0];
        lat_wea  <= wea_nxt;
        ram_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        ram_din  <= din_nxt;
      end
      if (state == S_ACCESS)
        cnt <= CNT_W'(RAM_LAT - 1);
      else if ((state == S_WAIT) && (cnt != '0))
        cnt <= cnt - CNT_W'(1);
      if (load_done)
        resp_rdata <= load_data;
      else if (store_done || (state == S_ERR))
        resp_rdata <= '0;
    end
  end

`ifdef DATA_MEM_STAT_EN
  logic [15:0] loads_q, stores_q, errs_q;

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else begin
      if (load_done && (loads_q != 16'hFFFF))
        loads_q <= loads_q + 16'd1;
      if (store_done && (stores_q != 16'hFFFF))
        stores_q <= stores_q + 16'd1;
      if ((state == S_ERR) && (errs_q != 16'hFFFF))
        errs_q <= errs_q + 16'd1;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`else
  assign stat_loads  = 16'h0000;
  assign stat_stores = 16'h0000;
  assign stat_errs   = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: two controllers (RAM_LAT=1 and RAM_LAT=3) each with a latency-pipelined RAM,
// driven by directed and random accesses and checked against a word-array memory model.
module tb_data_mem_ctrl;

  localparam int N = 2;

  logic                 clka = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid, req_we, req_unsigned;
  logic [N-1:0][1:0]    req_size;
  logic [N-1:0][31:0]   req_addr, req_wdata;
  logic [N-1:0]         req_ready, resp_valid, addr_err, stall, ram_en;
  logic [N-1:0][31:0]   resp_rdata, ram_addr, ram_din, ram_dout;
  logic [N-1:0][3:0]    ram_wea;
  logic [N-1:0][15:0]   stat_loads, stat_stores, stat_errs;

  logic [31:0] ref_mem [N][64];
  int          m_loads [N];
  int          m_stores[N];
  int          m_errs  [N];
  int          total = 0;
  int          bad   = 0;

  always #5 clka = ~clka;

  function automatic logic [31:0] pat(int k);
    return (32'h9E3779B9 * (k + 1)) ^ 32'h5A5A0000;
  endfunction

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem  [64];
    logic [31:0] pipe [3];

    data_mem_ctrl #(.ADDR_W(32), .RAM_LAT(LAT)) u_dut (
      .clka        (clka),
      .rst         (rst),
      .req_valid   (req_valid[g]),
      .req_we      (req_we[g]),
      .req_size    (req_size[g]),
      .req_unsigned(req_unsigned[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .req_ready   (req_ready[g]),
      .resp_valid  (resp_valid[g]),
      .resp_rdata  (resp_rdata[g]),
      .addr_err    (addr_err[g]),
      .stall       (stall[g]),
      .ram_en      (ram_en[g]),
      .ram_wea     (ram_wea[g]),
      .ram_addr    (ram_addr[g]),
      .ram_din     (ram_din[g]),
      .ram_dout    (ram_dout[g]),
      .stat_loads  (stat_loads[g]),
      .stat_stores (stat_stores[g]),
      .stat_errs   (stat_errs[g])
    );

    // RAM contents are refilled with a known pattern whenever reset is low.
    always @(posedge clka) begin
      if (!rst) begin
        for (int k = 0; k < 64; k++) mem[k] <= pat(k);
      end else if (ram_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wea[g][b]) mem[ram_addr[g][7:2]][8*b +: 8] <= ram_din[g][8*b +: 8];
        pipe[0] <= mem[ram_addr[g][7:2]];
      end
      for (int s = 1; s < 3; s++) pipe[s] <= pipe[s-1];
    end
    assign ram_dout[g] = pipe[LAT-1];
  end

  task automatic check(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h exp=%h", tag, i, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 64; k++) ref_mem[i][k] = pat(k);
      m_loads[i] = 0; m_stores[i] = 0; m_errs[i] = 0;
    end
  endtask

  function automatic logic [31:0] load_ref(int i, logic [1:0] sz, logic uns, logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[i][a[7:2]];
    if (sz == 2'd0) begin
      w = (w >> (8 * a[1:0])) & 32'hFF;
      if (!uns && w[7]) w = w | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      w = (w >> (16 * a[1])) & 32'hFFFF;
      if (!uns && w[15]) w = w | 32'hFFFF0000;
    end
    return w;
  endfunction

  function automatic logic is_mis(logic [1:0] sz, logic [31:0] a);
    return ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'b00));
  endfunction

  // Model of a committed store: expected lane enables and replicated data, applied to ref_mem.
  task automatic store_ref(input int i, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                           output logic [3:0] ewea, output logic [31:0] edin);
    if (sz == 2'd0) begin
      ewea = 4'(1 << a[1:0]);
      edin = {4{wd[7:0]}};
    end else if (sz == 2'd1) begin
      ewea = a[1] ? 4'b1100 : 4'b0011;
      edin = {2{wd[15:0]}};
    end else begin
      ewea = 4'hF;
      edin = wd;
    end
    for (int b = 0; b < 4; b++)
      if (ewea[b]) ref_mem[i][a[7:2]][8*b +: 8] = edin[8*b +: 8];
  endtask

  task automatic set_req(input int i, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    req_we[i] = we; req_size[i] = sz; req_unsigned[i] = uns; req_addr[i] = a; req_wdata[i] = wd;
  endtask

  task automatic wait_resp(input int i, output int n);
    n = 0;
    while (resp_valid[i] !== 1'b1 && n < 20) begin
      @(posedge clka); #1;
      n++;
    end
  endtask

  // One complete access from an idle controller; called and returns at posedge+1.
  task automatic xact(input int i, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    logic        mis;
    logic [3:0]  ewea;
    logic [31:0] edin, exp_rd;
    int          n, lat;
    mis = is_mis(sz, a);
    lat = (mis || we) ? 1 : lat_of(i) + 1;
    exp_rd = (mis || we) ? 32'h0 : load_ref(i, sz, uns, a);
    set_req(i, we, sz, uns, a, wd);
    req_valid[i] = 1'b1;
    check("ready_idle", i, req_ready[i], 1);
    @(posedge clka); #1;
    req_valid[i] = 1'b0;
    set_req(i, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    if (mis) begin
      check("err_en", i, ram_en[i], 0);
      check("err_wea", i, ram_wea[i], 0);
    end else begin
      check("acc_en", i, ram_en[i], 1);
      check("acc_addr", i, ram_addr[i], {a[31:2], 2'b00});
      if (we) begin
        store_ref(i, sz, a, wd, ewea, edin);
        check("st_wea", i, ram_wea[i], ewea);
        check("st_din", i, ram_din[i], edin);
      end else begin
        check("ld_wea", i, ram_wea[i], 0);
      end
    end
    wait_resp(i, n);
    check("latency", i, n, lat);
    check("rdata", i, resp_rdata[i], exp_rd);
    check("addr_err", i, addr_err[i], mis);
    if (mis) m_errs[i]++;
    else if (we) m_stores[i]++;
    else m_loads[i]++;
    @(posedge clka); #1;
    check("pulse_end", i, {addr_err[i], resp_valid[i]}, 0);
    check("rdata_hold", i, resp_rdata[i], exp_rd);
  endtask

  // sw / lw / sw with req_valid held high throughout: every response cycle accepts the next request.
  task automatic b2b(input int i);
    logic [3:0]  ewea;
    logic [31:0] edin, exp_ld;
    int          n;
    set_req(i, 1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678);
    req_valid[i] = 1'b1;
    @(posedge clka); #1;
    store_ref(i, 2'd2, 32'h40, 32'h1234_5678, ewea, edin);
    check("b2b_stall", i, stall[i], 1);
    set_req(i, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    exp_ld = load_ref(i, 2'd2, 1'b0, 32'h40);
    wait_resp(i, n);
    check("b2b_lat0", i, n, 1);
    check("b2b_ready0", i, {req_ready[i], stall[i]}, 2'b10);
    m_stores[i]++;
    @(posedge clka); #1;
    set_req(i, 1'b1, 2'd2, 1'b0, 32'h44, 32'hCAFE_F00D);
    wait_resp(i, n);
    check("b2b_lat1", i, n, lat_of(i) + 1);
    check("b2b_ld", i, resp_rdata[i], exp_ld);
    check("b2b_ready1", i, req_ready[i], 1);
    m_loads[i]++;
    @(posedge clka); #1;
    req_valid[i] = 1'b0;
    store_ref(i, 2'd2, 32'h44, 32'hCAFE_F00D, ewea, edin);
    wait_resp(i, n);
    check("b2b_lat2", i, n, 1);
    m_stores[i]++;
    @(posedge clka); #1;
    check("b2b_end", i, resp_valid[i], 0);
  endtask

  task automatic check_stats(input int i);
`ifdef DATA_MEM_STAT_EN
    check("stat_loads", i, stat_loads[i], m_loads[i]);
    check("stat_stores", i, stat_stores[i], m_stores[i]);
    check("stat_errs", i, stat_errs[i], m_errs[i]);
`else
    check("stat_off", i, {stat_loads[i], stat_stores[i] | stat_errs[i]}, 0);
`endif
  endtask

  task automatic check_reset_outputs(input int i);
    check("rst_ready", i, req_ready[i], 1);
    check("rst_resp", i, {resp_valid[i], addr_err[i]}, 0);
    check("rst_rdata", i, resp_rdata[i], 0);
    check("rst_ram", i, {ram_en[i], ram_wea[i]}, 0);
    check("rst_addr", i, ram_addr[i], 0);
    check("rst_din", i, ram_din[i], 0);
  endtask

  initial begin
    logic        we, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    int          n;
    rst = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    reset_model();
    repeat (3) @(posedge clka);
    #1;
    for (int i = 0; i < N; i++) begin
      check_reset_outputs(i);
      check_stats(i);
    end
    @(negedge clka); rst = 1'b1;
    @(posedge clka); #1;

    for (int i = 0; i < N; i++) begin
      xact(i, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
      xact(i, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      check("lw_deadbeef", i, resp_rdata[i], 32'hDEADBEEF);
      xact(i, 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AA);
      xact(i, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      check("lb_signed", i, resp_rdata[i], 32'hFFFFFFAA);
      xact(i, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      xact(i, 1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001);
      xact(i, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
      check("lh_signed", i, resp_rdata[i], 32'hFFFF8001);
      xact(i, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
      xact(i, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
      xact(i, 1'b1, 2'd2, 1'b0, 32'h16, 32'h0BAD0BAD);
      xact(i, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
      for (int t = 0; t < 40; t++) begin
        we  = 1'($urandom);
        sz  = 2'($urandom);
        uns = 1'($urandom);
        a   = $urandom;
        if ($urandom_range(0, 1) == 0) a[7:0] = a[7:0] & (sz == 2'd0 ? 8'hFF : sz == 2'd1 ? 8'hFE : 8'hFC);
        xact(i, we, sz, uns, a, $urandom);
        if ($urandom_range(0, 3) == 0) begin
          check("idle_ram", i, {ram_en[i], ram_wea[i]}, 0);
          @(posedge clka); #1;
        end
      end
      check_stats(i);
    end

    // Reset in the middle of a RAM_LAT=3 load.
    set_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    req_valid[1] = 1'b1;
    @(posedge clka); #1;
    req_valid[1] = 1'b0;
    @(posedge clka); #1;
    rst = 1'b0;
    reset_model();
    #1;
    check_reset_outputs(1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clka); #1;
      check("rst_no_resp", 1, resp_valid[1], 0);
    end
    @(negedge clka); rst = 1'b1;
    @(posedge clka); #1;
    check("rst_rel_ready", 1, req_ready[1], 1);
    xact(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("post_rst_lw", 1, resp_rdata[1], pat(4));

    for (int i = 0; i < N; i++) begin
      b2b(i);
      xact(i, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
      check("b2b_st2", i, resp_rdata[i], 32'hCAFE_F00D);
      check_stats(i);
    end
    check_stats(0);
    wait_resp(0, n);
    check("idle_no_resp", 0, n, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
